// File: rtl/morra_cinese.sv
// Rock-paper-scissors match referee.
// Scores each round and flags the end of the game.
module morra_cinese #(
    parameter int MIN_MANCHE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] PRIMO,
    input  logic [1:0] SECONDO,
    input  logic       INIZIA,
    output logic [1:0] MANCHE,
    output logic [1:0] PARTITA
);

    typedef enum logic [1:0] {
        INIT,
        PLAY,
        FINE
    } state_t;

    typedef enum logic [1:0] {
        LW_NONE,
        LW_P1,
        LW_P2
    } lw_t;

    state_t     state;
    lw_t        last_w;
    logic [1:0] last_mv;
    logic [4:0] max_m;
    logic [4:0] played;
    logic [4:0] wins1;
    logic [4:0] wins2;

    logic       tie;
    logic       p1_beats;
    logic       p2_beats;
    logic       repeat_mv;
    logic       rnd_ok;
    logic [1:0] rnd_res;
    logic [4:0] n_played;
    logic [4:0] n_w1;
    logic [4:0] n_w2;
    logic       lead1;
    logic       lead2;
    logic [1:0] game_res;
    logic [4:0] load_max;

    // Round evaluation and end-of-game check on post-update counts
    always_comb begin
        tie      = (PRIMO == SECONDO);
        p1_beats = ((PRIMO == 2'b01) && (SECONDO == 2'b11)) ||
                   ((PRIMO == 2'b11) && (SECONDO == 2'b10)) ||
                   ((PRIMO == 2'b10) && (SECONDO == 2'b01));
        p2_beats = !tie && !p1_beats;

        repeat_mv = ((last_w == LW_P1) && (PRIMO == last_mv)) ||
                    ((last_w == LW_P2) && (SECONDO == last_mv));
        rnd_ok = (PRIMO != 2'b00) && (SECONDO != 2'b00) && !repeat_mv;

        rnd_res = 2'b11;
        if (p1_beats) begin
            rnd_res = 2'b01;
        end else if (p2_beats) begin
            rnd_res = 2'b10;
        end

        n_played = played + 5'd1;
        n_w1     = wins1 + {4'b0, p1_beats};
        n_w2     = wins2 + {4'b0, p2_beats};

        lead1 = ({1'b0, n_w1}) >= ({1'b0, n_w2} + 6'd2);
        lead2 = ({1'b0, n_w2}) >= ({1'b0, n_w1} + 6'd2);

        game_res = 2'b00;
        if ((n_played >= 5'd4) && (lead1 || lead2)) begin
            game_res = lead1 ? 2'b01 : 2'b10;
        end else if (n_played == max_m) begin
            if (n_w1 > n_w2) begin
                game_res = 2'b01;
            end else if (n_w2 > n_w1) begin
                game_res = 2'b10;
            end else begin
                game_res = 2'b11;
            end
        end

        load_max = 5'(MIN_MANCHE) + {1'b0, PRIMO, SECONDO};
    end

    // Game FSM with registered round and game results
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            max_m   <= 5'(MIN_MANCHE);
            played  <= 5'd0;
            wins1   <= 5'd0;
            wins2   <= 5'd0;
            last_w  <= LW_NONE;
            last_mv <= 2'b00;
            MANCHE  <= 2'b00;
            PARTITA <= 2'b00;
        end else if (INIZIA) begin
            state   <= PLAY;
            max_m   <= load_max;
            played  <= 5'd0;
            wins1   <= 5'd0;
            wins2   <= 5'd0;
            last_w  <= LW_NONE;
            last_mv <= 2'b00;
            MANCHE  <= 2'b00;
            PARTITA <= 2'b00;
        end else begin
            unique case (state)
                INIT: begin
                    MANCHE  <= 2'b00;
                    PARTITA <= 2'b00;
                end
                FINE: begin
                    state   <= PLAY;
                    played  <= 5'd0;
                    wins1   <= 5'd0;
                    wins2   <= 5'd0;
                    last_w  <= LW_NONE;
                    last_mv <= 2'b00;
                    MANCHE  <= 2'b00;
                    PARTITA <= 2'b00;
                end
                PLAY: begin
                    if (rnd_ok) begin
                        played  <= n_played;
                        wins1   <= n_w1;
                        wins2   <= n_w2;
                        MANCHE  <= rnd_res;
                        PARTITA <= game_res;
                        if (p1_beats) begin
                            last_w  <= LW_P1;
                            last_mv <= PRIMO;
                        end else if (p2_beats) begin
                            last_w  <= LW_P2;
                            last_mv <= SECONDO;
                        end else begin
                            last_w  <= LW_NONE;
                            last_mv <= 2'b00;
                        end
                        if (game_res != 2'b00) begin
                            state <= FINE;
                        end
                    end else begin
                        MANCHE  <= 2'b00;
                        PARTITA <= 2'b00;
                    end
                end
                default: begin
                    state   <= INIT;
                    MANCHE  <= 2'b00;
                    PARTITA <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morra_cinese.sv
// Self-checking bench for the morra_cinese referee.
// Directed game scenarios plus randomized play against a reference model.
module tb_morra_cinese;

    logic       clk = 1'b0;
    logic       rst;
    logic       INIZIA;
    logic [1:0] PRIMO;
    logic [1:0] SECONDO;
    logic [1:0] MANCHE;
    logic [1:0] PARTITA;

    int tests_run    = 0;
    int tests_failed = 0;

    // reference model state: 0 idle, 1 playing, 2 just finished
    int m_st;
    int m_max;
    int m_pl;
    int m_w1;
    int m_w2;
    int m_lw;
    int m_lm;
    logic [1:0] exp_m;
    logic [1:0] exp_p;

    always #5 clk = ~clk;

    morra_cinese #(.MIN_MANCHE(4)) dut (
        .clk(clk),
        .rst(rst),
        .PRIMO(PRIMO),
        .SECONDO(SECONDO),
        .INIZIA(INIZIA),
        .MANCHE(MANCHE),
        .PARTITA(PARTITA)
    );

    // rock=1 paper=2 scissors=3: a beats b when a is one step ahead mod 3
    function automatic bit beats(input int a, input int b);
        return ((a - b + 3) % 3) == 1;
    endfunction

    task automatic model_clear();
        m_pl = 0;
        m_w1 = 0;
        m_w2 = 0;
        m_lw = 0;
        m_lm = 0;
    endtask

    task automatic model(input bit r, input int p, input int s, input bit i);
        int d;
        exp_m = 2'b00;
        exp_p = 2'b00;
        if (r) begin
            m_st  = 0;
            m_max = 4;
            model_clear();
        end else if (i) begin
            m_max = 4 + p * 4 + s;
            model_clear();
            m_st = 1;
        end else if (m_st == 2) begin
            model_clear();
            m_st = 1;
        end else if (m_st == 1) begin
            if (p != 0 && s != 0 &&
                !(m_lw == 1 && p == m_lm) &&
                !(m_lw == 2 && s == m_lm)) begin
                m_pl++;
                if (p == s) begin
                    exp_m = 2'b11;
                    m_lw  = 0;
                end else if (beats(p, s)) begin
                    exp_m = 2'b01;
                    m_w1++;
                    m_lw = 1;
                    m_lm = p;
                end else begin
                    exp_m = 2'b10;
                    m_w2++;
                    m_lw = 2;
                    m_lm = s;
                end
                d = m_w1 - m_w2;
                if (m_pl >= 4 && (d >= 2 || d <= -2)) begin
                    exp_p = (d > 0) ? 2'b01 : 2'b10;
                end else if (m_pl == m_max) begin
                    exp_p = (d > 0) ? 2'b01 : (d < 0) ? 2'b10 : 2'b11;
                end
                if (exp_p != 2'b00) m_st = 2;
            end
        end
    endtask

    task automatic step(input bit r, input logic [1:0] p,
                        input logic [1:0] s, input bit i);
        rst     = r;
        PRIMO   = p;
        SECONDO = s;
        INIZIA  = i;
        model(r, int'(p), int'(s), i);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 2'b11, 2'b11, 1'b0);
        tests_run++;
        if (MANCHE !== 2'b00 || PARTITA !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset got %b/%b want 00/00", MANCHE, PARTITA);
        end
        step(1'b1, 2'b01, 2'b01, 1'b1);
        tests_run++;
        if (MANCHE !== 2'b00 || PARTITA !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_prio got %b/%b want 00/00", MANCHE, PARTITA);
        end
        step(1'b0, 2'b01, 2'b11, 1'b0);
        tests_run++;
        if (MANCHE !== 2'b00 || PARTITA !== 2'b00) begin
            tests_failed++;
            $display("FAIL init_idle got %b/%b want 00/00", MANCHE, PARTITA);
        end
    endtask

    task automatic test_p2_game();
        logic [3:0] mv [0:6];
        logic [1:0] em [0:6];
        logic [1:0] ep;
        mv = '{4'b0011, 4'b1011, 4'b1111, 4'b0111, 4'b1101, 4'b1010, 4'b1111};
        em = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b11, 2'b11};
        step(1'b0, 2'b00, 2'b10, 1'b1);
        tests_run++;
        if (MANCHE !== 2'b00 || PARTITA !== 2'b00) begin
            tests_failed++;
            $display("FAIL p2_start got %b/%b want 00/00", MANCHE, PARTITA);
        end
        for (int k = 0; k < 7; k++) begin
            step(1'b0, mv[k][3:2], mv[k][1:0], 1'b0);
            ep = (k == 6) ? 2'b10 : 2'b00;
            tests_run++;
            if (MANCHE !== em[k] || PARTITA !== ep) begin
                tests_failed++;
                $display("FAIL p2_game[%0d] got %b/%b want %b/%b",
                         k, MANCHE, PARTITA, em[k], ep);
            end
        end
    endtask

    task automatic test_early_diff();
        logic [3:0] mv [0:3];
        logic [1:0] em [0:3];
        logic [1:0] ep;
        mv = '{4'b0111, 4'b1110, 4'b0111, 4'b1111};
        em = '{2'b01, 2'b01, 2'b01, 2'b11};
        step(1'b0, 2'b00, 2'b00, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, mv[k][3:2], mv[k][1:0], 1'b0);
            ep = (k == 3) ? 2'b01 : 2'b00;
            tests_run++;
            if (MANCHE !== em[k] || PARTITA !== ep) begin
                tests_failed++;
                $display("FAIL early_diff[%0d] got %b/%b want %b/%b",
                         k, MANCHE, PARTITA, em[k], ep);
            end
        end
    endtask

    task automatic test_late_p2();
        logic [3:0] mv [0:3];
        logic [1:0] em [0:3];
        logic [1:0] ep;
        mv = '{4'b0101, 4'b1010, 4'b1011, 4'b1101};
        em = '{2'b11, 2'b11, 2'b10, 2'b10};
        step(1'b0, 2'b00, 2'b00, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, mv[k][3:2], mv[k][1:0], 1'b0);
            ep = (k == 3) ? 2'b10 : 2'b00;
            tests_run++;
            if (MANCHE !== em[k] || PARTITA !== ep) begin
                tests_failed++;
                $display("FAIL late_p2[%0d] got %b/%b want %b/%b",
                         k, MANCHE, PARTITA, em[k], ep);
            end
        end
    endtask

    task automatic test_draw_game();
        logic [1:0] ep;
        step(1'b0, 2'b00, 2'b01, 1'b1);
        step(1'b0, 2'b00, 2'b00, 1'b0);
        tests_run++;
        if (MANCHE !== 2'b00 || PARTITA !== 2'b00) begin
            tests_failed++;
            $display("FAIL draw_invalid got %b/%b want 00/00", MANCHE, PARTITA);
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 2'b10, 2'b10, 1'b0);
            ep = (k == 4) ? 2'b11 : 2'b00;
            tests_run++;
            if (MANCHE !== 2'b11 || PARTITA !== ep) begin
                tests_failed++;
                $display("FAIL draw_game[%0d] got %b/%b want 11/%b",
                         k, MANCHE, PARTITA, ep);
            end
        end
    endtask

    task automatic test_dead_cycle();
        logic [3:0] mv [0:4];
        logic [1:0] em [0:4];
        logic [1:0] ep;
        mv = '{4'b1011, 4'b1001, 4'b0111, 4'b1101, 4'b0111};
        em = '{2'b10, 2'b01, 2'b01, 2'b10, 2'b01};
        step(1'b0, 2'b10, 2'b10, 1'b0);
        tests_run++;
        if (MANCHE !== 2'b00 || PARTITA !== 2'b00) begin
            tests_failed++;
            $display("FAIL dead_cycle got %b/%b want 00/00", MANCHE, PARTITA);
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b0, mv[k][3:2], mv[k][1:0], 1'b0);
            ep = (k == 4) ? 2'b01 : 2'b00;
            tests_run++;
            if (MANCHE !== em[k] || PARTITA !== ep) begin
                tests_failed++;
                $display("FAIL kept_max[%0d] got %b/%b want %b/%b",
                         k, MANCHE, PARTITA, em[k], ep);
            end
        end
    endtask

    task automatic test_reset_midgame();
        step(1'b0, 2'b00, 2'b11, 1'b1);
        step(1'b0, 2'b01, 2'b11, 1'b0);
        tests_run++;
        if (MANCHE !== 2'b01) begin
            tests_failed++;
            $display("FAIL mid_round got %b want 01", MANCHE);
        end
        step(1'b1, 2'b10, 2'b01, 1'b0);
        tests_run++;
        if (MANCHE !== 2'b00 || PARTITA !== 2'b00) begin
            tests_failed++;
            $display("FAIL mid_reset got %b/%b want 00/00", MANCHE, PARTITA);
        end
        step(1'b0, 2'b10, 2'b01, 1'b0);
        tests_run++;
        if (MANCHE !== 2'b00 || PARTITA !== 2'b00) begin
            tests_failed++;
            $display("FAIL mid_ignored got %b/%b want 00/00", MANCHE, PARTITA);
        end
        step(1'b0, 2'b00, 2'b00, 1'b1);
        step(1'b0, 2'b10, 2'b01, 1'b0);
        tests_run++;
        if (MANCHE !== 2'b01 || PARTITA !== 2'b00) begin
            tests_failed++;
            $display("FAIL mid_restart got %b/%b want 01/00", MANCHE, PARTITA);
        end
    endtask

    task automatic test_random();
        bit         r;
        bit         i;
        logic [1:0] p;
        logic [1:0] s;
        for (int k = 0; k < 800; k++) begin
            r = ($urandom_range(0, 99) == 0);
            i = ($urandom_range(0, 29) == 0);
            p = 2'($urandom_range(0, 3));
            s = 2'($urandom_range(0, 3));
            step(r, p, s, i);
            tests_run++;
            if (MANCHE !== exp_m || PARTITA !== exp_p) begin
                tests_failed++;
                $display("FAIL random[%0d] got %b/%b want %b/%b",
                         k, MANCHE, PARTITA, exp_m, exp_p);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        INIZIA  = 1'b0;
        PRIMO   = 2'b00;
        SECONDO = 2'b00;
        m_st    = 0;
        m_max   = 4;
        model_clear();
        exp_m = 2'b00;
        exp_p = 2'b00;
        test_reset();
        test_p2_game();
        test_early_diff();
        test_late_p2();
        test_draw_game();
        test_dead_cycle();
        test_reset_midgame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
